hazard_scoreboard_unit: RTL and testbench
=========================================

Name: hazard_scoreboard_unit

Overview:
Parametrised successor to the pipeline hazard unit, for a 5-stage in-order core with variable-latency data memory and a multi-cycle MDU. A per-register scoreboard tracks in-flight long-latency writes (loads, MDU ops). The block generates stall, flush and bubble controls for every pipeline register, plus a gated PC-redirect enable. It sits beside the ID stage and drives all pipeline-register enables.

Parameters:
NUM_REGS, 32, architectural registers; index width is REG_ADDR_WIDTH from riscv_pkg.
MDU_LATENCY, 4, EX-stage occupancy in cycles of an MDU op; must be at least 1.
MAX_OUTSTANDING, 4, maximum simultaneous pending scoreboard entries.
CNT_WIDTH, 32, width of each performance counter.

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
id_valid  in  1  valid instruction in ID
id_rs1_addr  in  REG_ADDR_WIDTH  ID source 1
id_rs2_addr  in  REG_ADDR_WIDTH  ID source 2
id_rs1_used  in  1  rs1 actually read
id_rs2_used  in  1  rs2 actually read
id_rd_addr  in  REG_ADDR_WIDTH  ID destination
id_rd_we  in  1  ID writes rd
id_is_load  in  1  ID instruction is a load
id_is_mdu  in  1  ID instruction is an MDU op
ex_branch_taken  in  1  taken branch or jump resolved in EX
mem_busy  in  1  dmem has not completed the MEM-stage access
wb_valid  in  1  WB-stage instruction valid
wb_we  in  1  WB writes register file
wb_rd_addr  in  REG_ADDR_WIDTH  WB destination
pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush  out  1 each  pipeline-register controls
pc_redirect_en  out  1  PC may take the branch target this cycle
issue_fire  out  1  ID instruction advances to EX this cycle
sb_stall_cnt, mem_stall_cnt, flush_cnt  out  CNT_WIDTH each  performance counters

Behaviour:
- Reset: reset is synchronous and active-low. While rst_n is 0 at a clk edge, the pending vector, outstanding count, MDU counter and performance counters all clear to 0. All outputs are combinational from this state; with idle inputs every output is 0.
- Scoreboard hazard (sb_haz): id_valid is high and any of the following holds:
  - pending[rs1] with id_rs1_used and rs1 != 0;
  - pending[rs2] with id_rs2_used and rs2 != 0;
  - pending[rd] with id_rd_we and rd != 0 (WAW);
  - (id_is_load or id_is_mdu) and outstanding == MAX_OUTSTANDING.
- Same-cycle WB clear: if a WB write clears a register this cycle, that register does not count as pending (the register file is write-first).
- mdu_busy: true while the MDU counter is nonzero. When issue_fire occurs with id_is_mdu, the counter loads MDU_LATENCY-1 and then decrements each cycle while mem_busy is low.
- Priority, highest first:
  1. mem_busy: pc, if_id, id_ex and ex_mem stall; mem_wb_flush (bubble); all other flushes 0; pc_redirect_en 0.
  2. mdu_busy: pc, if_id and id_ex stall; ex_mem_flush.
  3. ex_branch_taken: if_id_flush, id_ex_flush, pc_redirect_en.
  4. sb_haz: pc and if_id stall; id_ex_flush.
- A branch held in EX during mem_busy or mdu_busy redirects on the first cycle that both are low.
- issue_fire = id_valid & !sb_haz & !mem_busy & !mdu_busy & !ex_branch_taken.
- Pending set: issue_fire & id_rd_we & rd != 0 & (id_is_load | id_is_mdu) sets pending[rd].
- Pending clear: wb_valid & wb_we & pending[wb_rd_addr] clears pending[wb_rd_addr].
- Set and clear of the same register in one cycle: set wins. The outstanding count is then unchanged.
- Outstanding count is +1 per set and -1 per clear, and never leaves the range 0..MAX_OUTSTANDING.
- pending[0] is never set.
- mem_wb_stall and id_ex_stall during branch are always 0.

Optional Feature:
HAZARD_PERF_EN defined:
- sb_stall_cnt increments each cycle sb_haz stalls ID with priority 4 active.
- mem_stall_cnt increments each cycle mem_busy is high.
- flush_cnt increments each cycle pc_redirect_en is high.
- All three counters saturate at all-ones and clear on reset.

HAZARD_PERF_EN undefined: the three counter outputs are constant 0 and no counter flops exist.

Test Plan:
1. Load with rd=5 issues. Next instruction reads x5 with rs1_used=1. Hold WB idle for 3 cycles, then apply wb_valid/we with rd=5. Required: pc_stall=if_id_stall=id_ex_flush=1 for 3 cycles, then issue_fire=1 in the WB-clear cycle.
2. MDU op issues with MDU_LATENCY=4 and an independent instruction follows in ID. Required: pc_stall=id_ex_stall=ex_mem_flush=1 for exactly 3 cycles; issue_fire=0 during those cycles and 1 the cycle after.
3. ex_branch_taken=1 together with mem_busy=1 for 2 cycles. Required: pc_redirect_en=0 and no flushes for those 2 cycles, mem_wb_flush=1. On the 3rd cycle with mem_busy=0: pc_redirect_en=if_id_flush=id_ex_flush=1.
4. Issue 4 loads to x1..x4 with no WB, then a 5th load to x6. Required: 5th load stalled (sb_haz via full) until one WB clears, then issue_fire=1.
5. ID reads x0 while pending is all-zero, then issue a load with rd=0. Required: no stall, and pending stays 0.
6. Drive rst_n=0 for 1 cycle during a pending load and an MDU busy period. Required: next cycle all outputs 0, pending and counters cleared. With HAZARD_PERF_EN, counters read 0.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// Hazard/scoreboard control for a 5-stage in-order core with long-latency loads and MDU ops.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
package riscv_pkg;
  localparam int REG_ADDR_WIDTH = 5;
endpackage

module hazard_scoreboard_unit
  import riscv_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int MDU_LATENCY     = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                      id_rd_we,
  input  logic                      id_is_load,
  input  logic                      id_is_mdu,
  input  logic                      ex_branch_taken,
  input  logic                      mem_busy,
  input  logic                      wb_valid,
  input  logic                      wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_stall,
  output logic                      id_ex_flush,
  output logic                      ex_mem_stall,
  output logic                      ex_mem_flush,
  output logic                      mem_wb_stall,
  output logic                      mem_wb_flush,
  output logic                      pc_redirect_en,
  output logic                      issue_fire,
  output logic [CNT_WIDTH-1:0]      sb_stall_cnt,
  output logic [CNT_WIDTH-1:0]      mem_stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int MDU_W = $clog2(MDU_LATENCY + 1);

  logic [NUM_REGS-1:0] pending_q, pending_d, wb_clr_mask, pending_eff;
  logic [OUT_W-1:0]    outstanding_q, outstanding_d;
  logic [MDU_W-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic                wb_clr, full, sb_haz, mdu_busy, sb_set, sb_stall_now;

  // Handshake: an ID instruction advances exactly when issue_fire is high; there is no
  // separate ready, so every pipeline enable below is derived from the same priority chain.
  always_comb begin
    wb_clr      = wb_valid && wb_we && pending_q[wb_rd_addr];
    wb_clr_mask = '0;
    if (wb_clr) wb_clr_mask[wb_rd_addr] = 1'b1;
    // Register file is write-first, so a same-cycle WB clear already counts as resolved.
    pending_eff = pending_q & ~wb_clr_mask;
    full        = (outstanding_q - OUT_W'(wb_clr)) == OUT_W'(MAX_OUTSTANDING);
    sb_haz      = id_valid &&
                  ((id_rs1_used && (id_rs1_addr != '0) && pending_eff[id_rs1_addr]) ||
                   (id_rs2_used && (id_rs2_addr != '0) && pending_eff[id_rs2_addr]) ||
                   (id_rd_we    && (id_rd_addr  != '0) && pending_eff[id_rd_addr])  ||
                   ((id_is_load || id_is_mdu) && full));
    mdu_busy     = mdu_cnt_q != '0;
    issue_fire   = id_valid && !sb_haz && !mem_busy && !mdu_busy && !ex_branch_taken;
    sb_set       = issue_fire && id_rd_we && (id_rd_addr != '0) && (id_is_load || id_is_mdu);
    sb_stall_now = 1'b0;

    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_stall    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_stall   = 1'b0;
    ex_mem_flush   = 1'b0;
    mem_wb_stall   = 1'b0;
    mem_wb_flush   = 1'b0;
    pc_redirect_en = 1'b0;
    if (mem_busy) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mdu_busy) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      pc_redirect_en = 1'b1;
    end else if (sb_haz) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_flush  = 1'b1;
      sb_stall_now = 1'b1;
    end

    // Set wins over a same-register clear; the count then nets to unchanged.
    pending_d = pending_eff;
    if (sb_set) pending_d[id_rd_addr] = 1'b1;
    outstanding_d = outstanding_q;
    if (sb_set && !wb_clr && (outstanding_q != OUT_W'(MAX_OUTSTANDING)))
      outstanding_d = outstanding_q + OUT_W'(1);
    else if (wb_clr && !sb_set && (outstanding_q != '0))
      outstanding_d = outstanding_q - OUT_W'(1);

    mdu_cnt_d = mdu_cnt_q;
    if (issue_fire && id_is_mdu) mdu_cnt_d = MDU_W'(MDU_LATENCY - 1);
    else if (mdu_busy && !mem_busy) mdu_cnt_d = mdu_cnt_q - MDU_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      mdu_cnt_q     <= '0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      mdu_cnt_q     <= mdu_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] sb_stall_cnt_q, sb_stall_cnt_d;
  logic [CNT_WIDTH-1:0] mem_stall_cnt_q, mem_stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // All three counters saturate at all-ones rather than wrapping.
  always_comb begin
    sb_stall_cnt_d  = sb_stall_cnt_q;
    mem_stall_cnt_d = mem_stall_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    if (sb_stall_now && (sb_stall_cnt_q != '1))
      sb_stall_cnt_d = sb_stall_cnt_q + CNT_WIDTH'(1);
    if (mem_busy && (mem_stall_cnt_q != '1))
      mem_stall_cnt_d = mem_stall_cnt_q + CNT_WIDTH'(1);
    if (pc_redirect_en && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_stall_cnt_q  <= '0;
      mem_stall_cnt_q <= '0;
      flush_cnt_q     <= '0;
    end else begin
      sb_stall_cnt_q  <= sb_stall_cnt_d;
      mem_stall_cnt_q <= mem_stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign sb_stall_cnt  = sb_stall_cnt_q;
  assign mem_stall_cnt = mem_stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf   = sb_stall_now;
  assign sb_stall_cnt  = '0;
  assign mem_stall_cnt = '0;
  assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios plus random traffic against a
// register-array reference model (outstanding derived as a popcount of pending registers).
module tb_hazard_scoreboard_unit;
  localparam int AW          = riscv_pkg::REG_ADDR_WIDTH;
  localparam int MDU_LAT     = 4;
  localparam int MAX_OUT     = 4;
  localparam int CW          = 32;
  localparam longint CNT_MAX = (64'd1 << CW) - 1;

  localparam int PC_ST = 10, IFID_ST = 9, IFID_FL = 8, IDEX_ST = 7, IDEX_FL = 6;
  localparam int EXM_ST = 5, EXM_FL = 4, MW_ST = 3, MW_FL = 2, REDIR = 1, ISSUE = 0;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, id_is_mdu;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
  logic ex_branch_taken, mem_busy, wb_valid, wb_we;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush, pc_redirect_en, issue_fire;
  logic [CW-1:0] sb_stall_cnt, mem_stall_cnt, flush_cnt;

  hazard_scoreboard_unit #(
    .NUM_REGS(32), .MDU_LATENCY(MDU_LAT), .MAX_OUTSTANDING(MAX_OUT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd_addr(wb_rd_addr),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_stall(mem_wb_stall), .mem_wb_flush(mem_wb_flush),
    .pc_redirect_en(pc_redirect_en), .issue_fire(issue_fire),
    .sb_stall_cnt(sb_stall_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  string phase = "init";

  // reference model state
  bit     m_pend[32];
  int     m_mdu;
  longint m_sb, m_mem, m_fl;

  logic [10:0] obs_ctrl;
  logic [95:0] obs_cnt;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_mdu = 0; m_sb = 0; m_mem = 0; m_fl = 0;
  endtask

  // One clock: check outputs at negedge against the model, then advance the model at posedge.
  task automatic cycle();
    bit clr, haz, mb, full, iss, set, p1, p2, pd;
    int cnt;
    logic [10:0] e;
    logic [95:0] ec;
    @(negedge clk);
    clr = wb_valid && wb_we && m_pend[wb_rd_addr];
    cnt = 0;
    for (int r = 0; r < 32; r++) cnt += int'(m_pend[r]);
    full = (cnt - int'(clr)) == MAX_OUT;
    p1 = m_pend[id_rs1_addr] && !(clr && wb_rd_addr == id_rs1_addr);
    p2 = m_pend[id_rs2_addr] && !(clr && wb_rd_addr == id_rs2_addr);
    pd = m_pend[id_rd_addr]  && !(clr && wb_rd_addr == id_rd_addr);
    haz = id_valid && ((id_rs1_used && id_rs1_addr != 0 && p1) ||
                       (id_rs2_used && id_rs2_addr != 0 && p2) ||
                       (id_rd_we && id_rd_addr != 0 && pd) ||
                       ((id_is_load || id_is_mdu) && full));
    mb  = m_mdu > 0;
    iss = id_valid && !haz && !mem_busy && !mb && !ex_branch_taken;
    e = '0;
    if (mem_busy) begin
      e[PC_ST] = 1; e[IFID_ST] = 1; e[IDEX_ST] = 1; e[EXM_ST] = 1; e[MW_FL] = 1;
    end else if (mb) begin
      e[PC_ST] = 1; e[IFID_ST] = 1; e[IDEX_ST] = 1; e[EXM_FL] = 1;
    end else if (ex_branch_taken) begin
      e[IFID_FL] = 1; e[IDEX_FL] = 1; e[REDIR] = 1;
    end else if (haz) begin
      e[PC_ST] = 1; e[IFID_ST] = 1; e[IDEX_FL] = 1;
    end
    e[ISSUE] = iss;
`ifdef HAZARD_PERF_EN
    ec = {m_sb[CW-1:0], m_mem[CW-1:0], m_fl[CW-1:0]};
`else
    ec = '0;
`endif
    obs_ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
                ex_mem_flush, mem_wb_stall, mem_wb_flush, pc_redirect_en, issue_fire};
    obs_cnt  = {sb_stall_cnt, mem_stall_cnt, flush_cnt};
    check({phase, ":ctrl"}, 128'(obs_ctrl), 128'(e));
    check({phase, ":cnt"}, 128'(obs_cnt), 128'(ec));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (haz && !mem_busy && !mb && !ex_branch_taken && m_sb < CNT_MAX) m_sb++;
      if (mem_busy && m_mem < CNT_MAX) m_mem++;
      if (e[REDIR] && m_fl < CNT_MAX) m_fl++;
      set = iss && id_rd_we && id_rd_addr != 0 && (id_is_load || id_is_mdu);
      if (clr) m_pend[wb_rd_addr] = 1'b0;
      if (set) m_pend[id_rd_addr] = 1'b1;
      if (iss && id_is_mdu) m_mdu = MDU_LAT - 1;
      else if (m_mdu > 0 && !mem_busy) m_mdu--;
    end
    #1;
  endtask

  // driver tasks
  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit we, input bit ld, input bit md);
    id_valid = v; id_rs1_addr = AW'(rs1); id_rs1_used = u1;
    id_rs2_addr = AW'(rs2); id_rs2_used = u2;
    id_rd_addr = AW'(rd); id_rd_we = we; id_is_load = ld; id_is_mdu = md;
  endtask

  task automatic set_wb(input bit v, input int rd);
    wb_valid = v; wb_we = v; wb_rd_addr = AW'(rd);
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    ex_branch_taken = 0; mem_busy = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    model_reset();
    @(posedge clk); #1;

    phase = "reset";
    cycle();
    check("reset_idle", 128'(obs_ctrl), 128'(0));
    rst_n = 1;

    // 1: load-use through the scoreboard, released by the write-first WB clear
    phase = "t1";
    set_id(1, 0, 0, 0, 0, 5, 1, 1, 0);
    cycle(); check("t1_load_issue", 128'(obs_ctrl[ISSUE]), 128'(1));
    set_id(1, 5, 1, 0, 0, 7, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t1_stall", 128'({obs_ctrl[PC_ST], obs_ctrl[IFID_ST], obs_ctrl[IDEX_FL], obs_ctrl[ISSUE]}), 128'(4'b1110));
    end
    set_wb(1, 5);
    cycle(); check("t1_wb_release", 128'(obs_ctrl[ISSUE]), 128'(1));
    idle(); cycle();

    // 2: MDU occupancy stalls an independent follower for MDU_LATENCY-1 cycles
    phase = "t2";
    set_id(1, 0, 0, 0, 0, 8, 1, 0, 1);
    cycle(); check("t2_mdu_issue", 128'(obs_ctrl[ISSUE]), 128'(1));
    set_id(1, 1, 1, 2, 1, 9, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t2_busy", 128'({obs_ctrl[PC_ST], obs_ctrl[IDEX_ST], obs_ctrl[EXM_FL], obs_ctrl[ISSUE]}), 128'(4'b1110));
    end
    cycle(); check("t2_release", 128'(obs_ctrl[ISSUE]), 128'(1));
    idle(); set_wb(1, 8); cycle(); idle();

    // 3: branch held behind mem_busy, redirects once memory completes
    phase = "t3";
    ex_branch_taken = 1; mem_busy = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("t3_held", 128'({obs_ctrl[REDIR], obs_ctrl[IFID_FL], obs_ctrl[IDEX_FL], obs_ctrl[MW_FL]}), 128'(4'b0001));
    end
    mem_busy = 0;
    cycle();
    check("t3_redirect", 128'({obs_ctrl[REDIR], obs_ctrl[IFID_FL], obs_ctrl[IDEX_FL], obs_ctrl[MW_FL]}), 128'(4'b1110));
    idle();

    // 4: outstanding limit
    phase = "t4";
    for (int r = 1; r <= 4; r++) begin
      set_id(1, 0, 0, 0, 0, r, 1, 1, 0);
      cycle(); check("t4_fill", 128'(obs_ctrl[ISSUE]), 128'(1));
    end
    set_id(1, 0, 0, 0, 0, 6, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(); check("t4_full", 128'({obs_ctrl[PC_ST], obs_ctrl[ISSUE]}), 128'(2'b10));
    end
    set_wb(1, 1);
    cycle(); check("t4_release", 128'(obs_ctrl[ISSUE]), 128'(1));
    idle();
    for (int r = 2; r <= 6; r++) begin set_wb(1, r); cycle(); end
    idle();

    // 5: x0 is never a hazard and never becomes pending
    phase = "t5";
    for (int i = 0; i < 4; i++) begin
      set_id(1, 0, 1, 0, 1, 0, 1, 1, 0);
      cycle(); check("t5_x0", 128'({obs_ctrl[PC_ST], obs_ctrl[ISSUE]}), 128'(2'b01));
    end
    set_id(1, 0, 1, 0, 1, 10, 1, 1, 0);
    cycle(); check("t5_not_full", 128'(obs_ctrl[ISSUE]), 128'(1));
    idle(); set_wb(1, 10); cycle(); idle();

    // 6: reset during a pending load and an MDU busy period
    phase = "t6";
    set_id(1, 0, 0, 0, 0, 12, 1, 1, 0); cycle();
    set_id(1, 0, 0, 0, 0, 13, 1, 0, 1); cycle();
    idle(); rst_n = 0; cycle();
    rst_n = 1; cycle();
    check("t6_ctrl_zero", 128'(obs_ctrl), 128'(0));
    check("t6_cnt_zero", 128'(obs_cnt), 128'(0));
    set_id(1, 12, 1, 13, 1, 14, 1, 0, 0);
    cycle(); check("t6_cleared", 128'(obs_ctrl[ISSUE]), 128'(1));
    idle();

    // random traffic against the model
    phase = "rand";
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_busy        = ($urandom_range(0, 3) == 0);
      wb_valid        = $urandom_range(0, 1);
      wb_we           = ($urandom_range(0, 3) != 0);
      wb_rd_addr      = AW'($urandom_range(0, 7));
      cycle();
    end
    rst_n = 1; idle(); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
